// File: rtl/countdown_timer.sv
// Two-digit BCD round timer: loads START_BIG/START_SMALL on start and counts down once per clk_1hz edge.
// Optional low-time blink output is built only when COUNTDOWN_WARN_EN is defined.
module countdown_timer #(
  parameter int START_BIG   = 3,
  parameter int START_SMALL = 0,
  parameter int WARN_SECS   = 10
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] small_second,
  output logic [2:0] big_second,
  output logic       running,
  output logic       time_up,
  output logic       expired,
  output logic       warn,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam logic [3:0] LOAD_SMALL = 4'(START_SMALL);
  localparam logic [2:0] LOAD_BIG   = 3'(START_BIG);
  localparam logic       LOAD_ZERO  = (START_BIG == 0) && (START_SMALL == 0);

  // Out-of-range parameters are rejected at elaboration.
  if (START_BIG < 0 || START_BIG > 5 || START_SMALL < 0 || START_SMALL > 9 ||
      WARN_SECS < 0 || WARN_SECS > 99) begin : g_bad_cfg
    $error("countdown_timer: parameter out of legal range");
  end

  state_t     state, state_nxt;
  logic [3:0] small_nxt;
  logic [2:0] big_nxt;
  logic       time_up_nxt;

  // Handshake-free block: start/pause are plain levels sampled on each rising edge.
  always_comb begin
    state_nxt   = state;
    small_nxt   = small_second;
    big_nxt     = big_second;
    time_up_nxt = 1'b0;
    if (start) begin
      small_nxt   = LOAD_SMALL;
      big_nxt     = LOAD_BIG;
      state_nxt   = LOAD_ZERO ? EXPIRED : RUN;
      time_up_nxt = LOAD_ZERO;
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (small_second != 4'd0 || big_second != 3'd0) begin
            if (small_second != 4'd0) begin
              small_nxt = small_second - 4'd1;
            end else begin
              small_nxt = 4'd9;
              big_nxt   = big_second - 3'd1;
            end
            if (small_nxt == 4'd0 && big_nxt == 3'd0) begin
              state_nxt   = EXPIRED;
              time_up_nxt = 1'b1;
            end
          end else begin
            state_nxt = EXPIRED;
          end
        end
        PAUSED: begin
          if (!pause) state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      small_second <= LOAD_SMALL;
      big_second   <= LOAD_BIG;
      time_up      <= 1'b0;
    end else begin
      state        <= state_nxt;
      small_second <= small_nxt;
      big_second   <= big_nxt;
      time_up      <= time_up_nxt;
    end
  end

  assign running   = (state == RUN);
  assign expired   = (state == EXPIRED);
  assign fsm_state = state;

`ifdef COUNTDOWN_WARN_EN
  localparam logic [6:0] WARN_LIM = 7'(WARN_SECS);

  logic [6:0] cur_val, nxt_val;
  logic       cur_low, nxt_low;
  logic       warn_q, warn_nxt;

  always_comb begin
    cur_val = 7'(big_second) * 7'd10 + 7'(small_second);
    nxt_val = 7'(big_nxt) * 7'd10 + 7'(small_nxt);
    cur_low = (cur_val <= WARN_LIM);
    nxt_low = (nxt_val <= WARN_LIM);
    warn_nxt = 1'b0;
    case (state_nxt)
      EXPIRED: warn_nxt = 1'b1;
      PAUSED:  warn_nxt = nxt_low;
      // Blink only continues if the previous cycle was already a low-time RUN cycle.
      RUN:     warn_nxt = nxt_low && ((state == RUN && cur_low) ? ~warn_q : 1'b1);
      default: warn_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) warn_q <= 1'b0;
    else     warn_q <= warn_nxt;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;
  localparam int SB         = 3;
  localparam int SS         = 0;
  localparam int WS         = 10;
  localparam int START_SECS = SB * 10 + SS;

  logic       clk_1hz = 1'b0;
  logic       rst, start, pause;
  logic [3:0] small_second;
  logic [2:0] big_second;
  logic       running, time_up, expired, warn;
  logic [1:0] fsm_state;

  countdown_timer #(.START_BIG(SB), .START_SMALL(SS), .WARN_SECS(WS)) dut (
    .clk_1hz(clk_1hz), .rst(rst), .start(start), .pause(pause),
    .small_second(small_second), .big_second(big_second),
    .running(running), .time_up(time_up), .expired(expired),
    .warn(warn), .fsm_state(fsm_state)
  );

  always #5 clk_1hz = ~clk_1hz;

  int checks   = 0;
  int failures = 0;

  // Reference model: whole seconds plus a mode (0 idle, 1 run, 2 paused, 3 expired).
  int m_secs;
  int m_mode;
  bit m_tu;
  bit m_warn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = START_SECS;
    m_mode = 0;
    m_tu   = 1'b0;
    m_warn = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit p);
    int prev_mode = m_mode;
    int prev_secs = m_secs;
    m_tu = 1'b0;
    if (s) begin
      m_secs = START_SECS;
      if (m_secs == 0) begin m_mode = 3; m_tu = 1'b1; end
      else m_mode = 1;
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (m_secs > 0) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin m_mode = 3; m_tu = 1'b1; end
      end
    end else if (m_mode == 2) begin
      if (!p) m_mode = 1;
    end
    if (m_mode == 3) m_warn = 1'b1;
    else if (m_mode == 2 && m_secs <= WS) m_warn = 1'b1;
    else if (m_mode == 1 && m_secs <= WS)
      m_warn = (prev_mode == 1 && prev_secs <= WS) ? !m_warn : 1'b1;
    else m_warn = 1'b0;
  endtask

  task automatic check_all();
    bit exp_warn;
`ifdef COUNTDOWN_WARN_EN
    exp_warn = m_warn;
`else
    exp_warn = 1'b0;
`endif
    check("big_second",   32'(big_second),   32'(m_secs / 10));
    check("small_second", 32'(small_second), 32'(m_secs % 10));
    check("running",      32'(running),      32'(m_mode == 1));
    check("expired",      32'(expired),      32'(m_mode == 3));
    check("time_up",      32'(time_up),      32'(m_tu));
    check("warn",         32'(warn),         32'(exp_warn));
    check("state",        32'(fsm_state),    32'(m_mode));
  endtask

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input bit s, input bit p);
    start = s;
    pause = p;
    @(posedge clk_1hz);
    model_edge(s, p);
    #1;
    check_all();
  endtask

  // Reset pulse between edges; outputs must change without a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 64 && m_secs != target; i++) step(1'b0, 1'b0);
    check("run_to_reached", 32'(m_secs), 32'(target));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk_1hz);
    #1;
    check_all();
    rst = 1'b0;

    // Full countdown 30 -> 00, then hold in EXPIRED.
    step(1'b1, 1'b0);
    for (int i = 0; i < START_SECS; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Restart from EXPIRED, pause at 25 for three edges, resume.
    step(1'b1, 1'b0);
    run_to(25);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Restart during RUN at 12; start+pause together.
    run_to(12);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Reload at the edge that would reach 00.
    run_to(1);
    step(1'b1, 1'b0);

    // Asynchronous reset at 17, pause ignored in IDLE.
    run_to(17);
    async_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) < 2) async_reset();
      else step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
